// File: rtl/const_arith_pkg.sv
// -----------------------------------------------------------------------------
// const_arith_pkg
// Constants shared between the constant-arithmetic datapath and its sequential
// inverse (const_div_seq). Both sides use the same default divisor, so a
// product num*CONST_DIVISOR produced upstream divides back to num here.
// Also holds the divider FSM state encoding.
// -----------------------------------------------------------------------------
package const_arith_pkg;

  // Constant shared with the constant-arithmetic block.
  localparam int unsigned CONST_DIVISOR    = 7;

  // Default datapath widths.
  localparam int unsigned WIDTH_IN_DEFAULT = 16;
  localparam int unsigned WIDTH_Q_DEFAULT  = 8;

  // Widest quotient/remainder the divider is meant to be built with.
  localparam int unsigned WIDTH_Q_MAX      = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : const_arith_pkg

// File: rtl/const_div_seq_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division step by a compile-time constant. The next dividend
// bit is shifted into the partial remainder; if the result is >= DIVISOR the
// divisor is subtracted and the quotient bit is 1.
//
// Ports:
//   rem_i    partial remainder before this step (always < DIVISOR)
//   bit_i    next dividend bit, MSB first
//   rem_o    partial remainder after this step (always < DIVISOR)
//   q_bit_o  quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH_Q = 8,
  parameter int DIVISOR = 7
) (
  input  logic [WIDTH_Q-1:0] rem_i,
  input  logic               bit_i,
  output logic [WIDTH_Q-1:0] rem_o,
  output logic               q_bit_o
);

  localparam logic [WIDTH_Q:0] DIV_C = (WIDTH_Q + 1)'(DIVISOR);

  // rem_i < DIVISOR <= 2**WIDTH_Q-1, so the shifted value needs one extra bit.
  logic [WIDTH_Q:0] shifted;

  assign shifted = {rem_i, bit_i};
  assign q_bit_o = (shifted >= DIV_C);
  // After a subtraction the difference is < DIVISOR, so the top bit is zero.
  assign rem_o   = q_bit_o ? WIDTH_Q'(shifted - DIV_C) : shifted[WIDTH_Q-1:0];

endmodule : div_step

// File: rtl/const_div_seq.sv
// -----------------------------------------------------------------------------
// const_div_seq
// Sequential divider by a compile-time constant. Recovers quotient and
// remainder from a WIDTH_IN-bit value (typically num*DIVISOR from the
// constant-arithmetic datapath), one quotient bit per clock.
//
// Optional feature: define CONST_DIV_ROUND_EN to round the quotient half-up
// (remainder still reports the truncated value). Undefined: floor division.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   dividend valid
//   in_ready   block can accept a dividend (IDLE and not in reset)
//   dividend   value to divide, sampled at the accept edge only
//   out_valid  result valid (DONE), held until out_ready
//   out_ready  consumer accepts the result
//   quotient   dividend/DIVISOR, saturated to all ones
//   remainder  dividend mod DIVISOR
//   ovf        true quotient did not fit in WIDTH_Q bits
//
// Timing: accept edge, WIDTH_IN step cycles, one finalise cycle, so out_valid
// rises WIDTH_IN+1 clocks after the accept edge.
// -----------------------------------------------------------------------------
module const_div_seq
  import const_arith_pkg::*;
#(
  parameter int WIDTH_IN = WIDTH_IN_DEFAULT,
  parameter int WIDTH_Q  = WIDTH_Q_DEFAULT,
  parameter int DIVISOR  = CONST_DIVISOR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH_IN-1:0] dividend,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH_Q-1:0]  quotient,
  output logic [WIDTH_Q-1:0]  remainder,
  output logic                ovf
);

  // Elaboration-time parameter guards.
  if (DIVISOR < 1 || DIVISOR > (2 ** WIDTH_Q) - 1) begin : g_bad_divisor
    $error("const_div_seq: DIVISOR out of range 1..2**WIDTH_Q-1");
  end
  if (WIDTH_Q > WIDTH_Q_MAX || WIDTH_IN <= WIDTH_Q) begin : g_bad_width
    $error("const_div_seq: need WIDTH_Q <= WIDTH_Q_MAX and WIDTH_IN > WIDTH_Q");
  end

  // Counter carries one extra bit: it runs WIDTH_IN-1 down to 0 with a step
  // each cycle, then wraps negative, which marks the finalise cycle.
  localparam int CW = $clog2(WIDTH_IN) + 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [WIDTH_IN-1:0] shift_q, shift_d;
  logic [WIDTH_Q-1:0]  rem_q, rem_d;
  logic [WIDTH_IN-1:0] quot_q, quot_d;
  logic [WIDTH_Q-1:0]  quotient_q, quotient_d;
  logic [WIDTH_Q-1:0]  remainder_q, remainder_d;
  logic                ovf_q, ovf_d;

  logic [WIDTH_Q-1:0]  step_rem;
  logic                step_q;
  logic [WIDTH_Q-1:0]  q_sat;
  logic                q_ovf;

  div_step #(
    .WIDTH_Q (WIDTH_Q),
    .DIVISOR (DIVISOR)
  ) u_step (
    .rem_i   (rem_q),
    .bit_i   (shift_q[WIDTH_IN-1]),
    .rem_o   (step_rem),
    .q_bit_o (step_q)
  );

  // Result finalisation from the full WIDTH_IN-bit internal quotient.
`ifdef CONST_DIV_ROUND_EN
  logic                round_up;
  logic [WIDTH_IN:0]   q_round;

  assign round_up = ({rem_q, 1'b0} >= (WIDTH_Q + 1)'(DIVISOR));
  // One extra bit so an all-ones quotient rounding up cannot wrap to zero.
  assign q_round  = {1'b0, quot_q} + (WIDTH_IN + 1)'(round_up);
  assign q_ovf    = |q_round[WIDTH_IN:WIDTH_Q];
  assign q_sat    = q_ovf ? '1 : q_round[WIDTH_Q-1:0];
`else
  assign q_ovf    = |quot_q[WIDTH_IN-1:WIDTH_Q];
  assign q_sat    = q_ovf ? '1 : quot_q[WIDTH_Q-1:0];
`endif

  // Held low through reset so nothing is accepted while rst_n is asserted.
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;

  // NOTE: every _d gets its hold value first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          shift_d = dividend;
          rem_d   = '0;
          quot_d  = '0;
          count_d = CW'(WIDTH_IN - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (count_q[CW-1]) begin
          quotient_d  = q_sat;
          remainder_d = rem_q;
          ovf_d       = q_ovf;
          state_d     = S_DONE;
        end else begin
          shift_d = {shift_q[WIDTH_IN-2:0], 1'b0};
          rem_d   = step_rem;
          quot_d  = {quot_q[WIDTH_IN-2:0], step_q};
          count_d = count_q - CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule : const_div_seq

// File: tb/tb_const_div_seq.sv
// -----------------------------------------------------------------------------
// tb_const_div_seq
// Scoreboard bench for const_div_seq with default parameters. Expected
// results come from integer division in the bench, pushed when a dividend is
// accepted and popped at the output handshake. Honours CONST_DIV_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_const_div_seq;

  localparam int WIDTH_IN = 16;
  localparam int WIDTH_Q  = 8;
  localparam int DIVISOR  = 7;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [WIDTH_IN-1:0] dividend = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [WIDTH_Q-1:0]  quotient;
  logic [WIDTH_Q-1:0]  remainder;
  logic                ovf;

  typedef struct {
    logic [WIDTH_Q-1:0] q;
    logic [WIDTH_Q-1:0] r;
    logic               o;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  const_div_seq #(
    .WIDTH_IN (WIDTH_IN),
    .WIDTH_Q  (WIDTH_Q),
    .DIVISOR  (DIVISOR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected summary before 500000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [WIDTH_IN-1:0] d);
    int   qf;
    int   r;
    exp_t e;
    qf = int'(d) / DIVISOR;
    r  = int'(d) % DIVISOR;
`ifdef CONST_DIV_ROUND_EN
    if (2 * r >= DIVISOR) qf++;
`endif
    e.o = (qf > 255);
    e.q = e.o ? 8'hFF : 8'(qf);
    e.r = 8'(r);
    return e;
  endfunction

  // Leaves the bench at a falling edge with in_ready high (or flags a timeout).
  task automatic wait_ready();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready && w < 50);
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // One transaction: hold = cycles of out_ready low once out_valid is up,
  // keep_valid = keep in_valid high (with another dividend) while BUSY.
  task automatic run_op(input logic [WIDTH_IN-1:0] d, input int hold, input bit keep_valid);
    int   lat = 0;
    bit   seen = 1'b0;
    exp_t e;
    wait_ready();
    in_valid  = 1'b1;
    dividend  = d;
    out_ready = (hold == 0);
    sb.push_back(model(d));
    @(posedge clk);
    #1;
    if (keep_valid) dividend = ~d;
    else in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (keep_valid) check("busy_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check($sformatf("latency_%0d", d), lat, WIDTH_IN + 1);
    if (!seen) begin
      void'(sb.pop_front());
      return;
    end
    e = sb[0];
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_result", {15'd0, ovf, remainder, quotient}, {15'd0, e.o, e.r, e.q});
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    e = sb.pop_front();
    check($sformatf("quotient_%0d", d), 32'(quotient), 32'(e.q));
    check($sformatf("remainder_%0d", d), 32'(remainder), 32'(e.r));
    check($sformatf("ovf_%0d", d), 32'(ovf), 32'(e.o));
    check("done_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Starts a division, then resets it during the eighth BUSY cycle.
  task automatic abort_op();
    wait_ready();
    in_valid  = 1'b1;
    dividend  = 16'd1785;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    rst_n = 1'b1;
    #1;
    check("abort_idle", 32'(in_ready), 32'd1);
    repeat (20) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("abort_no_result", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [WIDTH_IN-1:0] dirs [8];
    dirs = '{16'd49, 16'd0, 16'd1785, 16'd1792, 16'hFFFF, 16'd52, 16'd53, 16'd1789};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);

    foreach (dirs[i]) run_op(dirs[i], 0, 1'b0);
    run_op(16'd1234, 5, 1'b0);
    run_op(16'd300, 0, 1'b1);
    abort_op();
    run_op(16'd14, 0, 1'b0);
    repeat (6) run_op(16'($urandom_range(0, 65535)), int'($urandom_range(0, 2)), 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_const_div_seq
